// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave bus bundle for the input PIO: word address, select, write strobe and data paths.
// The interrupt line and the external input bus stay as plain ports on the PIO itself.
interface pio_in_edge_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: two-flop synchronizer on in_port, per-bit edge detect into a sticky
// write-1-to-clear capture register, and a maskable registered level interrupt.
module pio_in_edge_capture #(
  parameter int unsigned           DATA_WIDTH  = 27,
  parameter int unsigned           EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_in_edge_capture_if.slave  avs,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } addr_e;

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;

  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] irq_mask_next;
  logic [DATA_WIDTH-1:0] edge_capture_next;
  logic [DATA_WIDTH-1:0] read_mux;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr;
  addr_e                 addr;
  logic                  unused_wdata_bits;

  assign addr  = addr_e'(avs.address);
  assign wr    = avs.chipselect & ~avs.write_n;
  assign wdata = avs.writedata[DATA_WIDTH-1:0];

  // Bits of writedata above DATA_WIDTH-1 are architecturally ignored.
  assign unused_wdata_bits = ^avs.writedata;

  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    edge_det = '0;
    if (EDGE_TYPE == 0) begin
      edge_det = sync2 & ~prev;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~sync2 & prev;
    end else begin
      edge_det = sync2 ^ prev;
    end
  end

  // Clear is applied before the set so a same-cycle edge keeps the bit at 1.
  always_comb begin
    irq_mask_next     = irq_mask;
    edge_capture_next = edge_capture | edge_det;
    if (wr && addr == ADDR_MASK) begin
      irq_mask_next = wdata;
    end
    if (wr && addr == ADDR_EDGE) begin
      edge_capture_next = (edge_capture & ~wdata) | edge_det;
    end
  end

  // Read mux is not qualified by chipselect; it shows pre-clear register contents.
  always_comb begin
    read_mux = '0;
    case (addr)
      ADDR_DATA: read_mux = sync2;
      ADDR_MASK: read_mux = irq_mask;
      ADDR_EDGE: read_mux = edge_capture;
      default:   read_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= RESET_VALUE;
      sync2        <= RESET_VALUE;
      prev         <= RESET_VALUE;
      irq_mask     <= '0;
      edge_capture <= '0;
      avs.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      sync1        <= in_port;
      sync2        <= sync1;
      prev         <= sync2;
      irq_mask     <= irq_mask_next;
      edge_capture <= edge_capture_next;
      avs.readdata <= 32'(read_mux);
      irq          <= |(edge_capture_next & irq_mask_next);
    end
  end

endmodule
